// File: rtl/bram_stream_writer_pkg.sv
// -----------------------------------------------------------------------------
// bram_stream_writer_pkg
//   Shared definitions for the streaming block-RAM writer and its RAM model.
//
//   DEPTH / AW / DW : RAM geometry (1024 words x 16 bits, 10-bit address).
//   state_t         : writer FSM states, also driven out on the debug port.
//   clamp_count     : limits a requested burst length to the RAM depth.
// -----------------------------------------------------------------------------
package bram_stream_writer_pkg;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int DW    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  // A burst longer than the RAM would overwrite words it has already
  // written, so anything beyond DEPTH is treated as exactly one full pass.
  function automatic logic [AW:0] clamp_count(input logic [AW:0] req);
    logic [AW:0] depth_w;
    depth_w = (AW + 1)'(DEPTH);
    if (req > depth_w) begin
      return depth_w;
    end
    return req;
  endfunction

endpackage : bram_stream_writer_pkg

// File: rtl/bram_sdp_1024_16.sv
// -----------------------------------------------------------------------------
// bram_sdp_1024_16
//   Behavioural simple-dual-port RAM, 1024 x 16, written so that synthesis
//   maps it onto a single 18Kb block RAM.
//
//   Ports
//     clock  : single clock, rising edge
//     reset  : synchronous, active-low; clears only the read output register
//     we     : write enable
//     waddr  : write address
//     wdata  : write data
//     raddr  : read address
//     rdata  : registered read data, one cycle after raddr
//
//   The read is read-first: a read and a write to the same address at the
//   same edge return the word that was stored before that edge.
// -----------------------------------------------------------------------------
module bram_sdp_1024_16
  import bram_stream_writer_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  // Storage is deliberately left without a reset so it stays a block RAM.
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Non-blocking read of mem at the same edge as the write gives read-first
  // behaviour; the output register carries the only reset in this module.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rdata <= '0;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule : bram_sdp_1024_16

// File: rtl/bram_stream_writer.sv
// -----------------------------------------------------------------------------
// bram_stream_writer
//   Streams 16-bit words from a valid/ready source into consecutive addresses
//   of an internal 1024x16 RAM, starting at a programmable base address and
//   wrapping from 1023 to 0. An independent read port lets an address sweeper
//   dump the RAM contents.
//
//   Ports
//     clock     : single clock, rising edge
//     reset     : synchronous, active-low
//     start     : begin a burst (only looked at in IDLE)
//     base      : first write address, latched when start is accepted
//     count     : burst length in words; 0 = empty burst; >1024 clamps to 1024
//     in_valid  : source offers in_data this cycle
//     in_ready  : writer accepts a word this cycle (high exactly in FILL)
//     in_data   : word to write
//     busy      : burst in progress
//     done      : single-cycle pulse when a burst completes
//     wr_count  : words written in the current / most recent burst
//     rd_addr   : read address
//     rd_data   : read data, one cycle after rd_addr
//     checksum  : (only with BRAM_STREAM_WRITER_CHECKSUM_EN) modulo-2^16 sum
//                 of the words written in the current / most recent burst
//     state     : FSM state, for debug and assertion binding
//
//   Build option
//     BRAM_STREAM_WRITER_CHECKSUM_EN : adds the checksum output and its
//     accumulator. Without it the block is otherwise identical.
//
//   Handshake: a word transfers on a rising edge where in_valid and in_ready
//   are both high. in_ready does not depend on in_valid; the source may raise
//   or drop in_valid in any cycle, and in_data is only looked at when a
//   transfer happens. No RAM write occurs on any other edge.
// -----------------------------------------------------------------------------
module bram_stream_writer
  import bram_stream_writer_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   count,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   wr_count,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
`ifdef BRAM_STREAM_WRITER_CHECKSUM_EN
  output logic [DW-1:0] checksum,
`endif
  output state_t        state
);

  // Next RAM address to write; AW bits wide, so 1023 + 1 wraps to 0.
  logic [AW-1:0] wr_addr;
  // Words still to accept in this burst, 1..DEPTH while in FILL.
  logic [AW:0]   remaining;
  logic          hs;
  logic          start_ok;

  // in_ready is a registered copy of (state == FILL), so a transfer is simply
  // valid && ready.
  assign hs       = in_valid && in_ready;
  assign start_ok = (state == IDLE) && start;

  // ---------------------------------------------------------------------------
  // Control FSM. All status outputs are registered and always updated
  // together with state, so in_ready/busy equal (state == FILL) and done
  // equals (state == DONE) at every cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wr_count  <= '0;
      wr_addr   <= '0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            wr_count <= '0;
            if (count != '0) begin
              wr_addr   <= base;
              remaining <= clamp_count(count);
              state     <= FILL;
              in_ready  <= 1'b1;
              busy      <= 1'b1;
            end else begin
              // Empty burst: report completion without touching the RAM.
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end

        FILL: begin
          if (in_valid) begin
            wr_addr   <= wr_addr + 1'b1;
            remaining <= remaining - 1'b1;
            wr_count  <= wr_count + 1'b1;
            if (remaining == (AW + 1)'(1)) begin
              state    <= DONE;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end
          end
        end

        DONE: begin
          // done is high for exactly this one cycle; start is not looked at
          // here, so a start held high across the end of a burst is ignored
          // until the block is back in IDLE.
          state <= IDLE;
          done  <= 1'b0;
        end

        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

`ifdef BRAM_STREAM_WRITER_CHECKSUM_EN
  // ---------------------------------------------------------------------------
  // Burst checksum: cleared on every accepted start (including empty bursts),
  // accumulates each transferred word, then holds until the next start.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      checksum <= '0;
    end else if (start_ok) begin
      checksum <= '0;
    end else if (hs) begin
      checksum <= checksum + in_data;
    end
  end
`else
  // start_ok only feeds the checksum; keep it referenced in the plain build.
  logic start_ok_unused;
  assign start_ok_unused = start_ok;
`endif

  // ---------------------------------------------------------------------------
  // RAM: write port fed straight from the handshake, read port free-running.
  // ---------------------------------------------------------------------------
  bram_sdp_1024_16 u_ram (
    .clock (clock),
    .reset (reset),
    .we    (hs),
    .waddr (wr_addr),
    .wdata (in_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule : bram_stream_writer

// File: tb/tb_bram_stream_writer.sv
// -----------------------------------------------------------------------------
// tb_bram_stream_writer
//   Self-checking bench for bram_stream_writer. The reference model is a plain
//   word array indexed by (base + n) mod 1024, filled in send order; the bench
//   decides on its own which cycles carry a transfer (in_valid while a burst
//   is open), so every expected value comes from the bench.
// -----------------------------------------------------------------------------
module tb_bram_stream_writer;
  import bram_stream_writer_pkg::*;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT signals
  // ---------------------------------------------------------------------------
  logic          clock    = 1'b0;
  logic          reset    = 1'b0;
  logic          start    = 1'b0;
  logic [AW-1:0] base     = '0;
  logic [AW:0]   count    = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data  = '0;
  logic          busy;
  logic          done;
  logic [AW:0]   wr_count;
  logic [AW-1:0] rd_addr  = '0;
  logic [DW-1:0] rd_data;
  state_t        state;
`ifdef BRAM_STREAM_WRITER_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  always #5 clock = ~clock;

  bram_stream_writer dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .base     (base),
    .count    (count),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .busy     (busy),
    .done     (done),
    .wr_count (wr_count),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
`ifdef BRAM_STREAM_WRITER_CHECKSUM_EN
    .checksum (checksum),
`endif
    .state    (state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int            total = 0;
  int            bad   = 0;
  logic [DW-1:0] ref_mem   [DEPTH];
  bit            ref_known [DEPTH];
  logic [DW-1:0] exp_q[$];          // words for the next burst, in send order
  logic [DW-1:0] rd_at_done;
  logic [DW-1:0] rd_after_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver: one burst.
  //   mode 0: in_valid held high; mode 1: high, low, high, ...;
  //   mode 2: random, forced high every third cycle.
  //   hold_start keeps start high (with base/count scrambled) for the whole
  //   burst. abort_after >= 0 pulls reset low after that many transfers.
  // ---------------------------------------------------------------------------
  task automatic run_burst(input logic [AW-1:0] b, input logic [AW:0] c, input int mode,
                           input bit hold_start, input int abort_after);
    int            k;
    int            cyc;
    int            n_hs;
    logic [DW-1:0] sum;
    logic [AW-1:0] a;
    k = (int'(c) > DEPTH) ? DEPTH : int'(c);

    @(posedge clock);
    #1;
    start    = 1'b1;
    base     = b;
    count    = c;
    in_valid = 1'b0;
    @(posedge clock);   // start accepted at this edge
    #1;
    if (hold_start) begin
      base  = ~b;
      count = c + 11'd3;
    end else begin
      start = 1'b0;
    end

    sum  = '0;
    n_hs = 0;
    cyc  = 0;
    while (n_hs < k) begin
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = (cyc % 2 == 0);
        default: in_valid = (cyc % 3 == 2) ? 1'b1 : 1'($urandom_range(0, 1));
      endcase
      in_data = in_valid ? exp_q[0] : 16'($urandom);
      @(negedge clock);
      check("fill_in_ready", in_ready, 1);
      check("fill_busy", busy, 1);
      check("fill_done", done, 0);
      check("fill_wr_count", wr_count, n_hs);
      @(posedge clock);
      cyc++;
      if (in_valid) begin
        a          = b + AW'(n_hs);
        ref_mem[a] = exp_q[0];
        ref_known[a] = 1'b1;
        sum        = sum + exp_q.pop_front();
        n_hs++;
      end
      #1;
      if (abort_after >= 0 && n_hs == abort_after) break;
    end
    in_valid = 1'b0;

    if (abort_after >= 0) begin
      reset = 1'b0;
      start = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b1;
      @(negedge clock);
      check("abort_state", state, IDLE);
      check("abort_busy", busy, 0);
      check("abort_in_ready", in_ready, 0);
      check("abort_done", done, 0);
      check("abort_wr_count", wr_count, 0);
`ifdef BRAM_STREAM_WRITER_CHECKSUM_EN
      check("abort_checksum", checksum, 0);
`endif
      @(posedge clock);
      @(negedge clock);
      check("abort_no_done", done, 0);
      check("abort_still_idle", state, IDLE);
      exp_q.delete();
      return;
    end

    // Done must be high in the cycle right after the last transfer edge
    // (or right after the start edge for an empty burst).
    @(negedge clock);
    check("done_pulse", done, 1);
    check("done_state", state, DONE);
    check("done_busy", busy, 0);
    check("done_in_ready", in_ready, 0);
    check("done_wr_count", wr_count, k);
`ifdef BRAM_STREAM_WRITER_CHECKSUM_EN
    check("done_checksum", checksum, sum);
`endif
    rd_at_done = rd_data;
    @(posedge clock);   // DONE -> IDLE; a held start is still high here
    #1;
    start = 1'b0;
    @(negedge clock);
    check("post_done_low", done, 0);
    check("post_state_idle", state, IDLE);
    check("post_busy", busy, 0);
    check("post_wr_count", wr_count, k);
`ifdef BRAM_STREAM_WRITER_CHECKSUM_EN
    check("post_checksum", checksum, sum);
`endif
    rd_after_done = rd_data;
    if (hold_start) begin
      @(posedge clock);
      @(negedge clock);
      check("hold_no_restart", state, IDLE);
      check("hold_no_second_done", done, 0);
    end
  endtask

  // Read sweep with one-cycle latency; only addresses the model knows are checked.
  task automatic sweep(input int first, input int n);
    logic [AW-1:0] a;
    for (int i = 0; i < n; i++) begin
      a       = AW'(first + i);
      rd_addr = a;
      @(posedge clock);
      @(negedge clock);
      if (ref_known[a]) check($sformatf("rd_%0d", a), rd_data, ref_mem[a]);
    end
  endtask

  task automatic push_random(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(16'($urandom));
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [DW-1:0] old7;
    for (int i = 0; i < DEPTH; i++) begin
      ref_known[i] = 1'b0;
      ref_mem[i]   = '0;
    end

    // Reset held low for 3 cycles.
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wr_count", wr_count, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_state", state, IDLE);
`ifdef BRAM_STREAM_WRITER_CHECKSUM_EN
    check("rst_checksum", checksum, 0);
`endif
    @(posedge clock);
    #1;
    reset = 1'b1;

    // 16 words from address 0, continuous valid.
    for (int i = 0; i < 16; i++) exp_q.push_back(16'h1000 + 16'(i));
    run_burst(10'd0, 11'd16, 0, 1'b0, -1);
`ifdef BRAM_STREAM_WRITER_CHECKSUM_EN
    check("t1_checksum_const", checksum, 16'h0078);
`endif
    sweep(0, 16);

    // Wrap: 1020..1023 then 0..3; address 4 keeps 0x1004.
    for (int i = 0; i < 8; i++) exp_q.push_back(16'hA0 + 16'(i));
    run_burst(10'd1020, 11'd8, 0, 1'b0, -1);
    sweep(1020, 4);
    sweep(0, 5);

    // Alternating valid, 4 words: done 8 cycles after start.
    push_random(4);
    run_burst(10'd100, 11'd4, 1, 1'b0, -1);
    sweep(100, 4);

    // Empty burst at a known region: nothing may change.
    run_burst(10'd0, 11'd0, 0, 1'b0, -1);
    sweep(0, 5);

    // start held high for the whole burst.
    push_random(6);
    run_burst(10'd300, 11'd6, 0, 1'b1, -1);
    sweep(300, 6);

    // Pre-load 405..409, then abort a 10-word burst at 400 after 5 words.
    push_random(5);
    run_burst(10'd405, 11'd5, 0, 1'b0, -1);
    push_random(10);
    run_burst(10'd400, 11'd10, 0, 1'b0, 5);
    sweep(400, 10);

    // Same-cycle read and write at address 7.
    exp_q.push_back(16'h1234);
    run_burst(10'd7, 11'd1, 0, 1'b0, -1);
    old7    = ref_mem[7];
    rd_addr = 10'd7;
    exp_q.push_back(16'hBEEF);
    run_burst(10'd7, 11'd1, 0, 1'b0, -1);
    check("rw_same_old", rd_at_done, old7);
    check("rw_same_new", rd_after_done, ref_mem[7]);

    // Random bursts with random valid.
    for (int t = 0; t < 6; t++) begin
      int n;
      n = $urandom_range(1, 40);
      push_random(n);
      run_burst(10'($urandom), 11'(n), 2, 1'b0, -1);
    end

    // Oversized count clamps to one full pass of the RAM.
    push_random(DEPTH);
    run_burst(10'($urandom), 11'd1500, 0, 1'b0, -1);
    sweep(0, DEPTH);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_bram_stream_writer
